// File: rtl/uba_intr_ack.sv
// uba_intr_ack: Unibus adapter interrupt-acknowledge sequencer. Arbitrates BR7..BR4 for an
// acknowledged PI level, grants the winner and returns its vector, with a bounded timeout.
`timescale 1ns/1ps
`default_nettype none

module uba_intr_ack #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ackREQ,
  input  logic [0:2]  ackPI,
  input  logic [0:2]  statPIH,
  input  logic [0:2]  statPIL,
  input  logic [7:4]  devINTR,
  output logic [7:4]  devACK,
  input  logic        devVECTV,
  input  logic [15:0] devVECT,
  output logic        ackDONE,
  output logic [15:0] ackVECT,
  output logic        ackTMO,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARB   = 2'd1;
  localparam logic [1:0] S_GRANT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [0:2]  pi_q, pi_d;
  logic [0:2]  pih_q, pih_d;
  logic [0:2]  pil_q, pil_d;
  logic [7:4]  intr_q, intr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:4]  dev_ack_q, dev_ack_d;
  logic        ack_done_q, ack_done_d;
  logic [15:0] ack_vect_q, ack_vect_d;
  logic        ack_tmo_q, ack_tmo_d;

  logic        hi_elig;
  logic        lo_elig;
  logic [7:4]  win;
  logic        tmo_hit;

  // Selection works only from the snapshot taken when the request was accepted.
  assign hi_elig = (pi_q == pih_q) && (pih_q != 3'd0) && (intr_q[7] || intr_q[6]);
  assign lo_elig = (pi_q == pil_q) && (pil_q != 3'd0) && (intr_q[5] || intr_q[4]);

  always_comb begin
    win = 4'b0000;
    if (hi_elig) begin
      win = intr_q[7] ? 4'b1000 : 4'b0100;
    end else if (lo_elig) begin
      win = intr_q[5] ? 4'b0010 : 4'b0001;
    end
  end

  assign tmo_hit = ((cnt_q + 8'd1) == TMO_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pi_q       <= 3'd0;
      pih_q      <= 3'd0;
      pil_q      <= 3'd0;
      intr_q     <= 4'b0000;
      cnt_q      <= 8'd0;
      dev_ack_q  <= 4'b0000;
      ack_done_q <= 1'b0;
      ack_vect_q <= 16'd0;
      ack_tmo_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pi_q       <= pi_d;
      pih_q      <= pih_d;
      pil_q      <= pil_d;
      intr_q     <= intr_d;
      cnt_q      <= cnt_d;
      dev_ack_q  <= dev_ack_d;
      ack_done_q <= ack_done_d;
      ack_vect_q <= ack_vect_d;
      ack_tmo_q  <= ack_tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ackREQ) state_d = S_ARB;
      S_ARB:   state_d = (win != 4'b0000) ? S_GRANT : S_DONE;
      S_GRANT: if (devVECTV || tmo_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pi_d       = pi_q;
    pih_d      = pih_q;
    pil_d      = pil_q;
    intr_d     = intr_q;
    cnt_d      = cnt_q;
    dev_ack_d  = dev_ack_q;
    ack_done_d = 1'b0;
    ack_vect_d = ack_vect_q;
    ack_tmo_d  = ack_tmo_q;
    case (state_q)
      S_IDLE: begin
        if (ackREQ) begin
          pi_d   = ackPI;
          pih_d  = statPIH;
          pil_d  = statPIL;
          intr_d = devINTR;
        end
      end
      S_ARB: begin
        if (win != 4'b0000) begin
          dev_ack_d = win;
          cnt_d     = 8'd0;
        end else begin
          ack_done_d = 1'b1;
          ack_vect_d = 16'd0;
          ack_tmo_d  = 1'b1;
        end
      end
      S_GRANT: begin
        // A vector arriving on the last permitted cycle beats the timeout.
        if (devVECTV) begin
          dev_ack_d  = 4'b0000;
          ack_done_d = 1'b1;
          ack_vect_d = devVECT;
          ack_tmo_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (tmo_hit) begin
            dev_ack_d  = 4'b0000;
            ack_done_d = 1'b1;
            ack_vect_d = 16'd0;
            ack_tmo_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        dev_ack_d = 4'b0000;
      end
      default: begin
        dev_ack_d = 4'b0000;
      end
    endcase
  end

  assign devACK  = dev_ack_q;
  assign ackDONE = ack_done_q;
  assign ackVECT = ack_vect_q;
  assign ackTMO  = ack_tmo_q;
  assign busy    = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uba_intr_ack.sv
// tb_uba_intr_ack: scoreboard bench for uba_intr_ack; stimulus pushes expected acknowledge
// results, a monitor pops them on every ackDONE.
`timescale 1ns/1ps
`default_nettype none

module tb_uba_intr_ack;

  localparam int TMO = 15;

  logic        clk;
  logic        rst;
  logic        ackREQ;
  logic [0:2]  ackPI;
  logic [0:2]  statPIH;
  logic [0:2]  statPIL;
  logic [7:4]  devINTR;
  logic [7:4]  devACK;
  logic        devVECTV;
  logic [15:0] devVECT;
  logic        ackDONE;
  logic [15:0] ackVECT;
  logic        ackTMO;
  logic        busy;

  uba_intr_ack #(.TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .ackREQ   (ackREQ),
    .ackPI    (ackPI),
    .statPIH  (statPIH),
    .statPIL  (statPIL),
    .devINTR  (devINTR),
    .devACK   (devACK),
    .devVECTV (devVECTV),
    .devVECT  (devVECT),
    .ackDONE  (ackDONE),
    .ackVECT  (ackVECT),
    .ackTMO   (ackTMO),
    .busy     (busy)
  );

  typedef struct {
    logic [3:0]  grant;
    int          gcycles;
    int          done_cyc;
    logic [15:0] vect;
    logic        tmo;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  logic [3:0] g_val;
  int         g_cnt;
  bit         g_changed;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: every BR belongs to a group with an assigned level; the highest-numbered
  // pending BR whose group level is nonzero and matches the acknowledged level wins.
  function automatic logic [3:0] ref_grant(input logic [2:0] pi, input logic [2:0] pih,
                                           input logic [2:0] pil, input logic [3:0] intr);
    logic [2:0] lvl;
    for (int b = 3; b >= 0; b--) begin
      lvl = (b >= 2) ? pih : pil;
      if (intr[b] && lvl != 3'd0 && lvl == pi) return 4'(1 << b);
    end
    return 4'b0000;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      g_cnt = 0; g_changed = 0; g_val = 4'b0000;
    end else begin
      if (devACK != 4'b0000) begin
        if (g_cnt == 0) g_val = devACK;
        else if (devACK != g_val) g_changed = 1;
        g_cnt++;
      end
      if (ackDONE) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("grant_value", {28'd0, g_val}, {28'd0, mon_e.grant});
          chk("grant_cycles", g_cnt, mon_e.gcycles);
          chk("grant_stable", {31'd0, g_changed}, 32'd0);
          chk("done_cycle", cyc, mon_e.done_cyc);
          chk("ack_vect", {16'd0, ackVECT}, {16'd0, mon_e.vect});
          chk("ack_tmo", {31'd0, ackTMO}, {31'd0, mon_e.tmo});
          chk("devack_low_at_done", {28'd0, devACK}, 32'd0);
          chk("busy_at_done", {31'd0, busy}, 32'd1);
        end
        g_cnt = 0; g_changed = 0; g_val = 4'b0000;
      end
    end
  end

  // resp: grant cycle (1..TMO) on which the device returns its vector, 0 = never.
  task automatic run_txn(input logic [2:0] pi, input logic [2:0] pih, input logic [2:0] pil,
                         input logic [3:0] intr, input logic [3:0] post_intr,
                         input int resp, input logic [15:0] vec, input bit noise);
    exp_t e;
    int n;
    int cur;
    logic [3:0] g;
    @(posedge clk); #1;
    ackPI = pi; statPIH = pih; statPIL = pil; devINTR = intr; ackREQ = 1'b1;
    devVECTV = 1'($urandom_range(0, 1)); devVECT = 16'($urandom);
    n = cyc;
    g = ref_grant(pi, pih, pil, intr);
    e.grant = g;
    if (g == 4'b0000) begin
      e.gcycles = 0; e.done_cyc = n + 2; e.vect = 16'd0; e.tmo = 1'b1;
    end else if (resp >= 1 && resp <= TMO) begin
      e.gcycles = resp; e.done_cyc = n + 2 + resp; e.vect = vec; e.tmo = 1'b0;
    end else begin
      e.gcycles = TMO; e.done_cyc = n + 2 + TMO; e.vect = 16'd0; e.tmo = 1'b1;
    end
    exp_q.push_back(e);
    while (1) begin
      @(posedge clk); #1;
      cur = cyc;
      ackREQ  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      devINTR = post_intr;
      if (noise) begin
        ackPI = 3'($urandom_range(0, 7)); statPIH = 3'($urandom_range(0, 7));
        statPIL = 3'($urandom_range(0, 7));
      end
      devVECT = 16'($urandom);
      if (cur <= n + 1) devVECTV = 1'($urandom_range(0, 1));
      else if (g != 4'b0000 && resp >= 1 && resp <= TMO && cur == n + 1 + resp) begin
        devVECTV = 1'b1; devVECT = vec;
      end else devVECTV = 1'b0;
      if (cur >= e.done_cyc) break;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] pi, pih, pil;
    int sel, r;
    rst = 1'b0; ackREQ = 1'b0; ackPI = 3'd0; statPIH = 3'd0; statPIL = 3'd0;
    devINTR = 4'b0000; devVECTV = 1'b0; devVECT = 16'd0;
    #12;
    chk("rst_devack", {28'd0, devACK}, 32'd0);
    chk("rst_ackdone", {31'd0, ackDONE}, 32'd0);
    chk("rst_ackvect", {16'd0, ackVECT}, 32'd0);
    chk("rst_acktmo", {31'd0, ackTMO}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    #10 rst = 1'b1;
    repeat (2) @(posedge clk);

    run_txn(3'd3, 3'd3, 3'd0, 4'b1000, 4'b1000, 2, 16'o000254, 1'b0);
    run_txn(3'd5, 3'd5, 3'd5, 4'b0111, 4'b0111, 1, 16'h1234, 1'b0);
    run_txn(3'd5, 3'd5, 3'd5, 4'b0011, 4'b0011, 3, 16'h0ace, 1'b0);
    run_txn(3'd4, 3'd2, 3'd6, 4'b1111, 4'b1111, 1, 16'hbeef, 1'b0);
    run_txn(3'd0, 3'd0, 3'd0, 4'b0001, 4'b0001, 1, 16'hbeef, 1'b0);
    run_txn(3'd4, 3'd4, 3'd2, 4'b1000, 4'b1000, 0, 16'h0, 1'b0);
    run_txn(3'd4, 3'd4, 3'd2, 4'b1000, 4'b1000, TMO, 16'h5a5a, 1'b0);
    run_txn(3'd6, 3'd6, 3'd1, 4'b1000, 4'b0100, 4, 16'h0f0f, 1'b1);
    run_txn(3'd1, 3'd6, 3'd1, 4'b1101, 4'b0000, 2, 16'h7777, 1'b1);
    run_txn(3'd1, 3'd6, 3'd1, 4'b0100, 4'b0000, 1, 16'h1111, 1'b1);
    ackREQ = 1'b0;

    // Abort an in-progress grant with an asynchronous reset.
    run_txn(3'd3, 3'd3, 3'd0, 4'b0100, 4'b0100, 1, 16'hc0de, 1'b0);
    ackREQ = 1'b0;
    @(posedge clk); #1;
    ackPI = 3'd3; statPIH = 3'd3; statPIL = 3'd0; devINTR = 4'b1000; ackREQ = 1'b1;
    devVECTV = 1'b0;
    @(posedge clk); #1 ackREQ = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    chk("pre_reset_grant", {28'd0, devACK}, 32'h8);
    rst = 1'b0;
    #1;
    chk("abort_devack", {28'd0, devACK}, 32'd0);
    chk("abort_ackdone", {31'd0, ackDONE}, 32'd0);
    chk("abort_ackvect", {16'd0, ackVECT}, 32'd0);
    chk("abort_acktmo", {31'd0, ackTMO}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    run_txn(3'd3, 3'd3, 3'd0, 4'b1000, 4'b1000, 0, 16'h0, 1'b0);
    run_txn(3'd2, 3'd0, 3'd2, 4'b0011, 4'b0011, 5, 16'h2468, 1'b0);

    for (int k = 0; k < 80; k++) begin
      pih = 3'($urandom_range(0, 7));
      pil = 3'($urandom_range(0, 7));
      sel = int'($urandom_range(0, 2));
      pi  = (sel == 0) ? pih : (sel == 1) ? pil : 3'($urandom_range(0, 7));
      r   = int'($urandom_range(0, 4));
      run_txn(pi, pih, pil, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              (r == 0) ? 0 : int'($urandom_range(1, TMO)), 16'($urandom),
              1'($urandom_range(0, 1)));
    end
    ackREQ = 1'b0;
    devVECTV = 1'b0;

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uba_intr_ack.md
# uba_intr_ack

Unibus adapter interrupt-acknowledge sequencer, downstream of the UBA interrupt request logic. When the CPU acknowledges a PI level that the UBA has raised, it performs a "who are you" read. This block arbitrates among the pending Unibus bus requests BR7..BR4 that map to that level and grants the winning device. It then captures the vector that device returns and hands the result back to the CPU side, with a bounded timeout.

## Interface
Parameters:
- TIMEOUT, 15: number of grant cycles allowed for a device to return its vector (legal range 1..255).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- ackREQ  in  1  one-cycle pulse that starts an acknowledge cycle. Sampled only in IDLE.
- ackPI  in  [0:2]  PI level being acknowledged. Sampled with ackREQ.
- statPIH  in  [0:2]  PI level assigned to BR7/BR6 (high group).
- statPIL  in  [0:2]  PI level assigned to BR5/BR4 (low group).
- devINTR  in  [7:4]  device bus requests BR7..BR4.
- devACK  out  [7:4]  one-hot bus grant to the selected device. Registered.
- devVECTV  in  1  vector valid from the granted device.
- devVECT  in  [15:0]  device vector. Sampled only when devVECTV is high in GRANT.
- ackDONE  out  1  one-cycle completion pulse. Registered.
- ackVECT  out  [15:0]  returned vector. Valid with ackDONE and held until the next ackDONE.
- ackTMO  out  1  set with ackDONE when no vector was received, either because of a timeout or because no request was eligible. Held like ackVECT.
- busy  out  1  high in every state except IDLE.

## Operation
- State machine states: IDLE, ARB, GRANT, DONE.
- IDLE:
  - On ackREQ, register ackPI, statPIH, statPIL and the devINTR snapshot, then go to ARB.
  - Otherwise stay in IDLE.
- ARB: eligibility and selection use the registered snapshot only.
  - The high group is eligible when sPI == sPIH, sPIH != 0 and (BR7 | BR6).
  - The low group is eligible when sPI == sPIL, sPIL != 0 and (BR5 | BR4).
  - Winner: the highest-numbered pending BR in the high group if that group is eligible. Otherwise the highest-numbered pending BR in the low group if that group is eligible. Otherwise there is no winner.
  - If there is a winner, go to GRANT. devACK drives the winner's bit and the timeout counter clears to 0.
  - If there is no winner, go to DONE with ackVECT = 0 and ackTMO = 1.
- GRANT:
  - devACK is held constant for the whole state, even if the device drops its BR.
  - If devVECTV is high: latch devVECT into ackVECT, set ackTMO = 0, go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT: set ackVECT = 0 and ackTMO = 1, then go to DONE.
  - devVECTV on the final permitted cycle wins over the timeout.
- DONE:
  - ackDONE = 1 and devACK = 0.
  - Go to IDLE on the next cycle. ackREQ is ignored here.
- ackREQ is ignored in ARB, GRANT and DONE; there is no queueing.
- Counter width is 8 bits. The counter does not wrap because it stops at TIMEOUT.

## Timing
- Reset values (asynchronous, while rst = 0):
  - state = IDLE.
  - devACK = 0, ackDONE = 0, ackVECT = 0, ackTMO = 0, busy = 0, counter = 0.
- Asserting reset in the middle of a cycle aborts immediately: devACK drops without waiting for a clock edge, and no ackDONE is produced.
- Grant path, with ackREQ high in IDLE at cycle N:
  - ARB at N+1.
  - devACK high from N+2.
  - If devVECTV is first high at cycle M ≥ N+2, ackDONE is high at M+1 and devACK is low at M+1.
  - Minimum latency from ackREQ to ackDONE is 3 cycles.
- Timeout path: devACK is high for exactly TIMEOUT cycles (N+2 .. N+1+TIMEOUT), and ackDONE is at N+2+TIMEOUT.
- No-winner path: ackDONE at N+2; devACK is never asserted.
- After ackDONE at cycle D, the earliest ackREQ that is accepted is at D+1.
- Changes to devINTR after cycle N do not affect the selection.

## Test plan
- Basic grant: statPIH = 3, devINTR = 4'b1000, ackREQ with ackPI = 3, devVECTV at the second GRANT cycle with devVECT = 16'o000254 → devACK = 4'b1000 for 2 cycles, then ackDONE with ackVECT = 16'o000254 and ackTMO = 0.
- Priority:
  - statPIH = statPIL = 5, devINTR = 4'b0111, ackPI = 5 → devACK = 4'b0100 (BR6).
  - Repeat with devINTR = 4'b0011 → devACK = 4'b0010 (BR5).
- Level mismatch and zero level:
  - statPIH = 2, statPIL = 6, devINTR = 4'b1111, ackPI = 4 → no devACK, ackDONE at N+2 with ackTMO = 1 and ackVECT = 0.
  - statPIL = 0, devINTR = 4'b0001, ackPI = 0 → same result.
- Timeout, TIMEOUT = 15, device never responds:
  - devACK is high for exactly 15 cycles, ackDONE at N+17 with ackTMO = 1.
  - devVECTV on the 15th grant cycle instead → ackTMO = 0 and the vector is captured.
- Ignored requests and snapshot:
  - ackREQ pulses during GRANT and DONE → no second cycle.
  - devINTR changes from 4'b1000 to 4'b0100 at N+1 → grant is still BR7.
- Reset mid-GRANT: drive rst low asynchronously → devACK = 0 without waiting for a clock edge, all outputs return to their reset values, no ackDONE, and the next ackREQ after reset is released proceeds normally.
